hole_number_sequencer: RTL and testbench
========================================

HOLE_NUMBER_SEQUENCER -- requirements
Module: hole_number_sequencer

Interface
REQ-001 Parameter DISPLAY_FRAMES, default 60, frames each hole number stays visible (range 1..255).
REQ-002 Parameter GAP_FRAMES, default 8, blank frames between two displays (range 0..255).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 startOfFrame  input  1  one-clk pulse per VGA frame.
REQ-006 pocketEvent  input  6  one-clk pulse per hole; bit i = hole i+1 pocketed a ball.
REQ-007 holeNumber  output  3  hole to render, always in 1..6; drives hole_number.holeNumber.
REQ-008 showNumber  output  1  high while the renderer's drawing request may be used.
REQ-009 pendingMask  output  6  holes queued, not yet displayed.
REQ-010 busy  output  1  high in SHOW or GAP.

Function
REQ-011 Pending bit i SHALL set on the clk edge where pocketEvent[i]=1; repeated events for a pending hole merge (no count).
REQ-012 If pocketEvent[i] and the grant-clear of bit i occur on the same edge, set SHALL win.
REQ-013 FSM states IDLE, SHOW, GAP; from reset the FSM SHALL be in IDLE.
REQ-014 IDLE: if pendingMask != 0, the arbiter SHALL grant the first pending hole searching round-robin from lastGrant+1 (wrap 6->1); on that edge holeNumber<=granted, its pending bit clears, frame counter<=0, state<=SHOW.
REQ-015 Grant SHALL take effect the cycle after pending becomes non-zero (1-clk latency event->showNumber minimum 2 clks: pending set, then grant).
REQ-016 SHOW: showNumber=1; counter increments on each startOfFrame; on the startOfFrame where counter==DISPLAY_FRAMES-1, state SHALL go to GAP (counter<=0), or to IDLE if GAP_FRAMES==0.
REQ-017 GAP: showNumber=0; on the startOfFrame where counter==GAP_FRAMES-1, state<=IDLE.
REQ-018 Events arriving during SHOW/GAP, including for the hole currently shown, SHALL only set pending; that hole is re-shown after others per round-robin.
REQ-019 holeNumber SHALL hold its last granted value outside SHOW; it never leaves 1..6.
REQ-020 Frame counter 8 bits, no wrap beyond parameter limits; startOfFrame in IDLE ignored.
REQ-021 busy = (state != IDLE); showNumber = (state == SHOW); both registered-state decodes, no combinational path from inputs.
REQ-022 All six holes pending: order SHALL be strictly cyclic, each shown exactly once per pass.

Reset
REQ-023 On reset assertion, asynchronously: state=IDLE, pendingMask=0, counter=0, holeNumber=1, lastGrant=6, showNumber=0, busy=0.
REQ-024 Reset mid-SHOW SHALL drop all pending events; first grant after release searches from hole 1.

Structure
REQ-025 Shared package billiard_pkg: NUM_HOLES=6, hole-index typedef (3-bit), FSM state enum.
REQ-026 One sub-module round_robin_arb6: combinational pick from 6-bit request mask and 3-bit last-grant, outputs grant index + valid.

Verification
REQ-027 Reset release, pocketEvent=6'b000100 one clk -> pendingMask=000100 next clk, then holeNumber=3, showNumber=1; stays 60 startOfFrames, 8 blank frames, busy falls.
REQ-028 pocketEvent=6'b100001 same clk -> hole 1 shown, then hole 6; pendingMask 100000 during hole-1 display.
REQ-029 During SHOW of hole 2, pocketEvent=000010 -> pendingMask=000010, hole 2 re-shown after GAP.
REQ-030 Event for hole 4 on exact grant edge of hole 4 -> bit 4 remains set, hole 4 displayed twice.
REQ-031 DISPLAY_FRAMES=2, GAP_FRAMES=0, all 6 pending -> order 1,2,3,4,5,6, two frames each, no blank frames.
REQ-032 Assert reset mid-SHOW with pending=011000 -> outputs at reset values immediately, pending cleared, holeNumber=1.

Source files
------------

// File: rtl/billiard_pkg.sv
// Shared definitions for the billiard table hole-number display path.
package billiard_pkg;

  localparam int NUM_HOLES = 6;

  // Holes are numbered 1..6; zero is never a valid hole.
  typedef logic [2:0] hole_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/round_robin_arb6.sv
// Combinational round-robin pick over six hole requests, starting after the last grant.
module round_robin_arb6
  import billiard_pkg::*;
(
  input  logic [NUM_HOLES-1:0] i_req,
  input  hole_idx_t            i_lastGrant,
  output hole_idx_t            o_grant,
  output logic                 o_valid
);

  hole_idx_t w_cand;
  hole_idx_t w_pick;
  logic      w_found;

  // Walk the holes once in cyclic order; the first requesting hole wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = i_lastGrant;
    w_cand  = (i_lastGrant >= hole_idx_t'(NUM_HOLES)) ? hole_idx_t'(1)
                                                      : i_lastGrant + hole_idx_t'(1);
    for (int k = 0; k < NUM_HOLES; k++) begin
      if (!w_found && i_req[w_cand - hole_idx_t'(1)]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
      w_cand = (w_cand >= hole_idx_t'(NUM_HOLES)) ? hole_idx_t'(1)
                                                  : w_cand + hole_idx_t'(1);
    end
  end

  assign o_grant = w_pick;
  assign o_valid = w_found;

endmodule

// File: rtl/hole_number_sequencer.sv
// Queues pocketed-hole events and shows each hole number for a fixed number of frames.
module hole_number_sequencer
  import billiard_pkg::*;
#(
  parameter int DISPLAY_FRAMES = 60,
  parameter int GAP_FRAMES     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [NUM_HOLES-1:0] pocketEvent,
  output logic [2:0]           holeNumber,
  output logic                 showNumber,
  output logic [NUM_HOLES-1:0] pendingMask,
  output logic                 busy
);

  localparam logic [7:0] SHOW_LAST = 8'(DISPLAY_FRAMES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_FRAMES - 1);

  state_t               r_state;
  logic [NUM_HOLES-1:0] r_pending;
  logic [7:0]           r_counter;
  hole_idx_t            r_holeNumber;
  hole_idx_t            r_lastGrant;

  hole_idx_t            w_grant;
  logic                 w_grantValid;
  logic                 w_grantFire;
  logic [NUM_HOLES-1:0] w_clearMask;

  round_robin_arb6 u_arb (
    .i_req       (r_pending),
    .i_lastGrant (r_lastGrant),
    .o_grant     (w_grant),
    .o_valid     (w_grantValid)
  );

  assign w_grantFire = (r_state == ST_IDLE) && w_grantValid;
  assign w_clearMask = w_grantFire ? (6'b000001 << (w_grant - hole_idx_t'(1))) : '0;

  // New events are OR-ed in after the grant clear, so a same-edge event survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clearMask) | pocketEvent;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_counter    <= 8'd0;
      r_holeNumber <= hole_idx_t'(1);
      r_lastGrant  <= hole_idx_t'(NUM_HOLES);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grantFire) begin
            r_state      <= ST_SHOW;
            r_counter    <= 8'd0;
            r_holeNumber <= w_grant;
            r_lastGrant  <= w_grant;
          end
        end
        ST_SHOW: begin
          if (startOfFrame) begin
            if (r_counter == SHOW_LAST) begin
              r_counter <= 8'd0;
              r_state   <= (GAP_FRAMES == 0) ? ST_IDLE : ST_GAP;
            end else begin
              r_counter <= r_counter + 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (startOfFrame) begin
            if (r_counter == GAP_LAST) begin
              r_counter <= 8'd0;
              r_state   <= ST_IDLE;
            end else begin
              r_counter <= r_counter + 8'd1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_counter <= 8'd0;
        end
      endcase
    end
  end

  assign holeNumber  = r_holeNumber;
  assign showNumber  = (r_state == ST_SHOW);
  assign busy        = (r_state != ST_IDLE);
  assign pendingMask = r_pending;

endmodule

// File: tb/tb_hole_number_sequencer.sv
// Bench for hole_number_sequencer: default-parameter and short-parameter instances vs a queue-level model.
module tb_hole_number_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sofA = 1'b0, sofB = 1'b0;
  logic [5:0] evA = '0, evB = '0;
  logic [2:0] holeA, holeB;
  logic       showA, showB, busyA, busyB;
  logic [5:0] pendA, pendB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hole_number_sequencer #(.DISPLAY_FRAMES(60), .GAP_FRAMES(8)) dutA (
    .clk(clk), .reset(reset), .startOfFrame(sofA), .pocketEvent(evA),
    .holeNumber(holeA), .showNumber(showA), .pendingMask(pendA), .busy(busyA)
  );

  hole_number_sequencer #(.DISPLAY_FRAMES(2), .GAP_FRAMES(0)) dutB (
    .clk(clk), .reset(reset), .startOfFrame(sofB), .pocketEvent(evB),
    .holeNumber(holeB), .showNumber(showB), .pendingMask(pendB), .busy(busyB)
  );

  // phase: 0 idle, 1 showing, 2 blank gap; left counts remaining frames of the phase
  typedef struct {
    logic [5:0] pend;
    int         hole;
    int         last;
    int         phase;
    int         left;
  } model_t;

  typedef struct packed {
    logic       sof;
    logic [5:0] ev;
    logic [2:0] hole;
    logic       show;
    logic       busy;
    logic [5:0] pend;
  } vec_t;

  model_t mA, mB;
  vec_t   vecs[20];

  function automatic model_t modelReset();
    model_t m;
    m.pend = '0; m.hole = 1; m.last = 6; m.phase = 0; m.left = 0;
    return m;
  endfunction

  function automatic model_t modelStep(model_t m, logic sof, logic [5:0] ev, int dispF, int gapF);
    model_t n;
    int pick;
    int h;
    n = m;
    pick = 0;
    if (m.phase == 0) begin
      for (int k = 1; k <= 6; k++) begin
        h = (m.last + k - 1) % 6 + 1;
        if (pick == 0 && m.pend[h-1]) pick = h;
      end
      if (pick != 0) begin
        n.pend[pick-1] = 1'b0;
        n.hole = pick; n.last = pick; n.phase = 1; n.left = dispF;
      end
    end else if (sof) begin
      n.left = m.left - 1;
      if (n.left == 0) begin
        if (m.phase == 1 && gapF > 0) begin
          n.phase = 2; n.left = gapF;
        end else begin
          n.phase = 0;
        end
      end
    end
    n.pend = n.pend | ev;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModels();
    checkOutput("A.hole", 8'(holeA), 8'(mA.hole));
    checkOutput("A.show", 8'(showA), 8'(mA.phase == 1));
    checkOutput("A.busy", 8'(busyA), 8'(mA.phase != 0));
    checkOutput("A.pend", 8'(pendA), 8'(mA.pend));
    checkOutput("B.hole", 8'(holeB), 8'(mB.hole));
    checkOutput("B.show", 8'(showB), 8'(mB.phase == 1));
    checkOutput("B.busy", 8'(busyB), 8'(mB.phase != 0));
    checkOutput("B.pend", 8'(pendB), 8'(mB.pend));
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic applyStimulus(input logic sA, input logic [5:0] eA, input logic sB, input logic [5:0] eB);
    sofA = sA; evA = eA; sofB = sB; evB = eB;
    @(posedge clk);
    mA = modelStep(mA, sA, eA, 60, 8);
    mB = modelStep(mB, sB, eB, 2, 0);
    #1;
    compareModels();
    @(negedge clk);
    sofA = 1'b0; evA = '0; sofB = 1'b0; evB = '0;
  endtask

  task automatic runFrames(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, '0, 1'b0, '0);
      applyStimulus(1'b0, '0, 1'b0, '0);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    #2;
    mA = modelReset();
    mB = modelReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkA(input string tag, input int hole, input logic show, input logic busy, input logic [5:0] pend);
    checkOutput({tag, ".hole"}, 8'(holeA), 8'(hole));
    checkOutput({tag, ".show"}, 8'(showA), 8'(show));
    checkOutput({tag, ".busy"}, 8'(busyA), 8'(busy));
    checkOutput({tag, ".pend"}, 8'(pendA), 8'(pend));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 6'b111111, 3'd1, 1'b0, 1'b0, 6'b111111};
    vecs[1]  = '{1'b0, 6'b000000, 3'd1, 1'b1, 1'b1, 6'b111110};
    vecs[2]  = '{1'b1, 6'b000000, 3'd1, 1'b1, 1'b1, 6'b111110};
    vecs[3]  = '{1'b1, 6'b000000, 3'd1, 1'b0, 1'b0, 6'b111110};
    vecs[4]  = '{1'b1, 6'b000000, 3'd2, 1'b1, 1'b1, 6'b111100};
    vecs[5]  = '{1'b1, 6'b000000, 3'd2, 1'b1, 1'b1, 6'b111100};
    vecs[6]  = '{1'b1, 6'b000000, 3'd2, 1'b0, 1'b0, 6'b111100};
    vecs[7]  = '{1'b1, 6'b000000, 3'd3, 1'b1, 1'b1, 6'b111000};
    vecs[8]  = '{1'b1, 6'b000000, 3'd3, 1'b1, 1'b1, 6'b111000};
    vecs[9]  = '{1'b1, 6'b000000, 3'd3, 1'b0, 1'b0, 6'b111000};
    vecs[10] = '{1'b1, 6'b000000, 3'd4, 1'b1, 1'b1, 6'b110000};
    vecs[11] = '{1'b1, 6'b000000, 3'd4, 1'b1, 1'b1, 6'b110000};
    vecs[12] = '{1'b1, 6'b000000, 3'd4, 1'b0, 1'b0, 6'b110000};
    vecs[13] = '{1'b1, 6'b000000, 3'd5, 1'b1, 1'b1, 6'b100000};
    vecs[14] = '{1'b1, 6'b000000, 3'd5, 1'b1, 1'b1, 6'b100000};
    vecs[15] = '{1'b1, 6'b000000, 3'd5, 1'b0, 1'b0, 6'b100000};
    vecs[16] = '{1'b1, 6'b000000, 3'd6, 1'b1, 1'b1, 6'b000000};
    vecs[17] = '{1'b1, 6'b000000, 3'd6, 1'b1, 1'b1, 6'b000000};
    vecs[18] = '{1'b1, 6'b000000, 3'd6, 1'b0, 1'b0, 6'b000000};
    vecs[19] = '{1'b1, 6'b000000, 3'd6, 1'b0, 1'b0, 6'b000000};

    mA = modelReset();
    mB = modelReset();
    @(negedge clk);
    checkA("resetA", 1, 1'b0, 1'b0, 6'b000000);
    checkOutput("resetB.hole", 8'(holeB), 8'd1);
    checkOutput("resetB.busy", 8'(busyB), 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single event, default timing: 60 shown frames then 8 blank frames.
    applyStimulus(1'b0, 6'b000100, 1'b0, '0);
    checkA("single.pendSet", 1, 1'b0, 1'b0, 6'b000100);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkA("single.grant", 3, 1'b1, 1'b1, 6'b000000);
    runFrames(59);
    checkA("single.frame59", 3, 1'b1, 1'b1, 6'b000000);
    applyStimulus(1'b1, '0, 1'b0, '0);
    checkA("single.gapEntry", 3, 1'b0, 1'b1, 6'b000000);
    runFrames(7);
    checkA("single.gap7", 3, 1'b0, 1'b1, 6'b000000);
    applyStimulus(1'b1, '0, 1'b0, '0);
    checkA("single.idle", 3, 1'b0, 1'b0, 6'b000000);

    // Two simultaneous events: hole 1 first, then hole 6.
    doReset();
    applyStimulus(1'b0, 6'b100001, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkA("pair.first", 1, 1'b1, 1'b1, 6'b100000);
    runFrames(68);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkA("pair.second", 6, 1'b1, 1'b1, 6'b000000);

    // Re-pocket of the hole being shown is queued and re-shown later.
    doReset();
    applyStimulus(1'b0, 6'b000010, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    runFrames(3);
    applyStimulus(1'b0, 6'b000010, 1'b0, '0);
    checkA("repocket.queued", 2, 1'b1, 1'b1, 6'b000010);
    runFrames(68);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkA("repocket.reshow", 2, 1'b1, 1'b1, 6'b000000);

    // Event landing on the grant edge of the same hole.
    doReset();
    applyStimulus(1'b0, 6'b001000, 1'b0, '0);
    applyStimulus(1'b0, 6'b001000, 1'b0, '0);
    checkA("collide.setWins", 4, 1'b1, 1'b1, 6'b001000);
    runFrames(68);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkA("collide.second", 4, 1'b1, 1'b1, 6'b000000);

    // Short instance: all holes pending, strict cyclic order with no blank frames.
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, '0, vecs[i].sof, vecs[i].ev);
      checkOutput($sformatf("vec%0d.hole", i), 8'(holeB), 8'(vecs[i].hole));
      checkOutput($sformatf("vec%0d.show", i), 8'(showB), 8'(vecs[i].show));
      checkOutput($sformatf("vec%0d.busy", i), 8'(busyB), 8'(vecs[i].busy));
      checkOutput($sformatf("vec%0d.pend", i), 8'(pendB), 8'(vecs[i].pend));
    end

    // Asynchronous reset in the middle of a display drops queued holes.
    doReset();
    applyStimulus(1'b0, 6'b000100, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, 6'b011000, 1'b0, '0);
    runFrames(5);
    checkA("midReset.before", 3, 1'b1, 1'b1, 6'b011000);
    #2;
    reset = 1'b1;
    #1;
    checkA("midReset.async", 1, 1'b0, 1'b0, 6'b000000);
    mA = modelReset();
    mB = modelReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 6'b100001, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkA("midReset.searchFrom1", 1, 1'b1, 1'b1, 6'b100000);

    // Randomized traffic on both instances against the model.
    doReset();
    for (int i = 0; i < 5000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'b0,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : 6'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
